// File: rtl/parallel_frame_receiver.sv
//------------------------------------------------------------------------------
// Module  : parallel_frame_receiver
// Brief   : Oversampling receiver for the 8-bit parallel transfer port.
//           Synchronises DATA_CLK / FLAG_FRAME / DATA_IN, pairs bytes into
//           16-bit words, frames them on the ROI flag and queues them in a
//           first-word fall-through FIFO.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module parallel_frame_receiver #(
  parameter int FRAME_LENGTH    = 64,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int MIN_PHASE       = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DATA_CLK,
  input  logic        FLAG_FRAME,
  input  logic [7:0]  DATA_IN,
  output logic        DATA_ACK,
  output logic [15:0] WORD_OUT,
  output logic        WORD_VALID,
  input  logic        WORD_READY,
  output logic        FRAME_ACTIVE,
  output logic        FRAME_DONE,
  output logic        FRAME_ERROR,
  output logic        OVERFLOW,
  output logic [15:0] WORD_COUNT
);

  localparam int          c_DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int          c_CNT_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int          c_PH_W   = $clog2(MIN_PHASE + 1);
  localparam logic [15:0] c_LEN    = 16'(FRAME_LENGTH);
  localparam logic [c_PH_W-1:0]  c_PH_MAX = c_PH_W'(MIN_PHASE);
  localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(c_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HI_BYTE = 2'd1,
    S_LO_BYTE = 2'd2,
    S_ERR     = 2'd3
  } state_t;

  state_t r_state, w_nxt;

  logic       r_dclk_s1, r_dclk_s2, r_dclk_d;
  logic       r_flag_s1, r_flag_s2, r_flag_d;
  logic [7:0] r_din_s1, r_din_s2;
  logic [c_PH_W-1:0] r_lo_cnt;

  logic [7:0]  r_hi;
  logic [15:0] r_word;
  logic        r_pend;
  logic        r_after_done, r_excess;
  logic        r_ack, r_done, r_active, r_err, r_ovf;
  logic [15:0] r_word_count;

  logic [15:0]                r_mem [c_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_CNT_W-1:0]         r_fifo_cnt;

  logic w_dclk_ev, w_flag_rise, w_last;
  logic w_start, w_abort, w_err_set, w_excess_set;
  logic w_pop, w_full, w_push_ok;

  // Two-stage synchronisers on every port input plus one delay stage for edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_dclk_s1 <= 1'b0; r_dclk_s2 <= 1'b0; r_dclk_d <= 1'b0;
      r_flag_s1 <= 1'b0; r_flag_s2 <= 1'b0; r_flag_d <= 1'b0;
      r_din_s1  <= '0;   r_din_s2  <= '0;
      r_lo_cnt  <= '0;
    end else begin
      r_dclk_s1 <= DATA_CLK;   r_dclk_s2 <= r_dclk_s1; r_dclk_d <= r_dclk_s2;
      r_flag_s1 <= FLAG_FRAME; r_flag_s2 <= r_flag_s1; r_flag_d <= r_flag_s2;
      r_din_s1  <= DATA_IN;    r_din_s2  <= r_din_s1;
      if (r_dclk_s2)
        r_lo_cnt <= '0;
      else if (r_lo_cnt != c_PH_MAX)
        r_lo_cnt <= r_lo_cnt + 1'b1;
    end
  end

  // A rise only counts after a full minimum low phase, so a glitch cannot clock a byte.
  assign w_dclk_ev   = r_dclk_s2 & ~r_dclk_d & (r_lo_cnt == c_PH_MAX);
  assign w_flag_rise = r_flag_s2 & ~r_flag_d;
  assign w_last      = r_pend & (r_word_count == c_LEN - 16'd1);

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  // Next-state and framing strobes; frame length wins over a coincident flag drop.
  always_comb begin
    w_nxt        = r_state;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    w_err_set    = 1'b0;
    w_excess_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_flag_rise) begin
          w_nxt   = S_HI_BYTE;
          w_start = 1'b1;
        end else if (r_after_done && r_flag_s2 && w_dclk_ev) begin
          if (r_excess) begin
            w_nxt     = S_ERR;
            w_err_set = 1'b1;
          end else begin
            w_excess_set = 1'b1;
          end
        end
      end
      S_HI_BYTE: begin
        if (w_last) begin
          w_nxt = S_IDLE;
        end else if (!r_flag_s2) begin
          w_nxt     = S_IDLE;
          w_abort   = 1'b1;
          w_err_set = 1'b1;
        end else if (w_dclk_ev) begin
          w_nxt = S_LO_BYTE;
        end
      end
      S_LO_BYTE: begin
        if (w_dclk_ev) begin
          w_nxt = S_HI_BYTE;
        end else if (!r_flag_s2) begin
          w_nxt     = S_IDLE;
          w_abort   = 1'b1;
          w_err_set = 1'b1;
        end
      end
      default: begin
        w_err_set = 1'b1;
        if (!r_flag_s2) w_nxt = S_IDLE;
      end
    endcase
  end

  assign w_pop     = (r_fifo_cnt != '0) & WORD_READY;
  assign w_full    = (r_fifo_cnt == c_FULL);
  assign w_push_ok = r_pend & (~w_full | w_pop);

  // Byte assembly, word commit and frame status flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hi <= '0; r_word <= '0; r_pend <= 1'b0;
      r_after_done <= 1'b0; r_excess <= 1'b0;
      r_ack <= 1'b0; r_done <= 1'b0; r_active <= 1'b0;
      r_err <= 1'b0; r_ovf <= 1'b0; r_word_count <= '0;
    end else begin
      r_ack  <= w_push_ok;
      r_done <= w_last;
      r_pend <= 1'b0;
      if (r_state == S_HI_BYTE && w_nxt == S_LO_BYTE)
        r_hi <= r_din_s2;
      if (r_state == S_LO_BYTE && w_nxt == S_HI_BYTE) begin
        r_word <= {r_hi, r_din_s2};
        r_pend <= 1'b1;
      end
      if (w_start) begin
        r_word_count <= '0;
        r_err        <= 1'b0;
        r_active     <= 1'b1;
      end else begin
        if (r_pend && r_word_count != c_LEN) r_word_count <= r_word_count + 16'd1;
        if (w_last || w_abort)               r_active <= 1'b0;
        if (w_err_set)                       r_err <= 1'b1;
      end
      if (r_pend && !w_push_ok) r_ovf <= 1'b1;
      // Excess-byte tracking only lives while the previous frame's flag is still high.
      if (w_start || !r_flag_s2) begin
        r_after_done <= 1'b0;
        r_excess     <= 1'b0;
      end else begin
        if (w_last)       r_after_done <= 1'b1;
        if (w_excess_set) r_excess     <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; a pop in the same cycle makes room for a push.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_fifo_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop)      r_fifo_cnt <= r_fifo_cnt + 1'b1;
      else if (!w_push_ok && w_pop) r_fifo_cnt <= r_fifo_cnt - 1'b1;
    end
  end

  // FIFO storage needs no reset; the head is masked while empty.
  always_ff @(posedge CLK) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= r_word;
  end

  assign WORD_VALID   = (r_fifo_cnt != '0);
  assign WORD_OUT     = WORD_VALID ? r_mem[r_rd_ptr] : 16'd0;
  assign DATA_ACK     = r_ack;
  assign FRAME_ACTIVE = r_active;
  assign FRAME_DONE   = r_done;
  assign FRAME_ERROR  = r_err;
  assign OVERFLOW     = r_ovf;
  assign WORD_COUNT   = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_parallel_frame_receiver.sv
//------------------------------------------------------------------------------
// Module  : tb_parallel_frame_receiver
// Brief   : Directed scoreboard bench for parallel_frame_receiver.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_parallel_frame_receiver;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        DATA_CLK = 1'b0;
  logic        FLAG_FRAME = 1'b0;
  logic [7:0]  DATA_IN = 8'h00;
  logic        WORD_READY = 1'b0;
  logic        DATA_ACK, WORD_VALID, FRAME_ACTIVE, FRAME_DONE, FRAME_ERROR, OVERFLOW;
  logic [15:0] WORD_OUT, WORD_COUNT;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ack    = 0;
  int n_done   = 0;
  int n_pop    = 0;
  int done_wc  = -1;
  logic [15:0] exp_q[$];

  parallel_frame_receiver #(
    .FRAME_LENGTH(64), .FIFO_DEPTH_LOG2(2), .MIN_PHASE(3)
  ) dut (
    .CLK(CLK), .RESET(RESET), .DATA_CLK(DATA_CLK), .FLAG_FRAME(FLAG_FRAME),
    .DATA_IN(DATA_IN), .DATA_ACK(DATA_ACK), .WORD_OUT(WORD_OUT),
    .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY),
    .FRAME_ACTIVE(FRAME_ACTIVE), .FRAME_DONE(FRAME_DONE),
    .FRAME_ERROR(FRAME_ERROR), .OVERFLOW(OVERFLOW), .WORD_COUNT(WORD_COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: samples on the falling edge, pops the scoreboard on every transfer.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (DATA_ACK) n_ack++;
      if (FRAME_DONE) begin
        n_done++;
        done_wc = int'(WORD_COUNT);
      end
      if (WORD_VALID && WORD_READY) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%04h expected none", WORD_OUT);
        end else begin
          chk("word_out", int'(WORD_OUT), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    DATA_IN  = b;
    DATA_CLK = 1'b1;
    tick(4);
    DATA_CLK = 1'b0;
    tick(4);
  endtask

  task automatic send_word(input logic [7:0] hi, input logic [7:0] lo, input bit stored);
    if (stored) exp_q.push_back({hi, lo});
    send_byte(hi);
    send_byte(lo);
  endtask

  // Low byte whose commit cycle coincides with a one-cycle consumer pop.
  task automatic send_byte_pop(input logic [7:0] b);
    DATA_IN  = b;
    DATA_CLK = 1'b1;
    tick(3);
    WORD_READY = 1'b1;
    tick(1);
    WORD_READY = 1'b0;
    DATA_CLK   = 1'b0;
    tick(4);
  endtask

  task automatic do_reset();
    FLAG_FRAME = 1'b0;
    DATA_CLK   = 1'b0;
    RESET      = 1'b1;
    tick(3);
    RESET = 1'b0;
    tick(6);
  endtask

  task automatic frame_start();
    FLAG_FRAME = 1'b1;
    tick(5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, d0, p0;
    // Reset state
    RESET = 1'b1;
    tick(4);
    chk("rst_valid",  int'(WORD_VALID), 0);
    chk("rst_active", int'(FRAME_ACTIVE), 0);
    chk("rst_count",  int'(WORD_COUNT), 0);
    chk("rst_out",    int'(WORD_OUT), 0);
    chk("rst_flags",  int'({DATA_ACK, FRAME_DONE, FRAME_ERROR, OVERFLOW}), 0);
    RESET = 1'b0;
    tick(6);

    // 1: nominal frame
    WORD_READY = 1'b1;
    a0 = n_ack; d0 = n_done;
    frame_start();
    chk("t1_active", int'(FRAME_ACTIVE), 1);
    for (int i = 0; i < 64; i++) send_word(8'(2*i), 8'(2*i+1), 1'b1);
    tick(8);
    chk("t1_acks",   n_ack - a0, 64);
    chk("t1_done",   n_done - d0, 1);
    chk("t1_done_wc", done_wc, 64);
    chk("t1_err",    int'(FRAME_ERROR), 0);
    chk("t1_ovf",    int'(OVERFLOW), 0);
    chk("t1_active_end", int'(FRAME_ACTIVE), 0);
    chk("t1_q_empty", exp_q.size(), 0);
    FLAG_FRAME = 1'b0;
    tick(6);

    // 2: backpressure and overflow
    do_reset();
    WORD_READY = 1'b0;
    a0 = n_ack;
    frame_start();
    for (int i = 0; i < 6; i++) send_word(8'(8'hA0 + 2*i), 8'(8'hA1 + 2*i), i < 4);
    tick(4);
    chk("t2_acks",  n_ack - a0, 4);
    chk("t2_ovf",   int'(OVERFLOW), 1);
    chk("t2_count", int'(WORD_COUNT), 6);
    chk("t2_valid", int'(WORD_VALID), 1);
    p0 = n_pop;
    WORD_READY = 1'b1;
    tick(8);
    chk("t2_pops",  n_pop - p0, 4);
    chk("t2_valid_end", int'(WORD_VALID), 0);
    chk("t2_q_empty", exp_q.size(), 0);

    // 3: early flag drop
    do_reset();
    WORD_READY = 1'b1;
    d0 = n_done;
    frame_start();
    for (int i = 0; i < 10; i++) send_word(8'(8'h40 + 2*i), 8'(8'h41 + 2*i), 1'b1);
    send_byte(8'h77);
    FLAG_FRAME = 1'b0;
    tick(8);
    chk("t3_err",    int'(FRAME_ERROR), 1);
    chk("t3_active", int'(FRAME_ACTIVE), 0);
    chk("t3_done",   n_done - d0, 0);
    chk("t3_count",  int'(WORD_COUNT), 10);
    chk("t3_q_empty", exp_q.size(), 0);
    frame_start();
    chk("t3_err_clr", int'(FRAME_ERROR), 0);
    chk("t3_active2", int'(FRAME_ACTIVE), 1);
    FLAG_FRAME = 1'b0;
    tick(6);

    // 4: push and pop together on a full FIFO
    do_reset();
    WORD_READY = 1'b0;
    a0 = n_ack;
    frame_start();
    for (int i = 0; i < 4; i++) send_word(8'(8'h10 + 2*i), 8'(8'h11 + 2*i), 1'b1);
    exp_q.push_back(16'h1819);
    send_byte(8'h18);
    send_byte_pop(8'h19);
    tick(2);
    chk("t4_ovf",  int'(OVERFLOW), 0);
    chk("t4_acks", n_ack - a0, 5);
    p0 = n_pop;
    WORD_READY = 1'b1;
    tick(8);
    chk("t4_pops", n_pop - p0, 4);
    chk("t4_q_empty", exp_q.size(), 0);

    // 5: reset mid-frame, then a clean frame
    do_reset();
    WORD_READY = 1'b1;
    frame_start();
    for (int i = 0; i < 16; i++) send_word(8'(8'hC0 + i), 8'(i), 1'b1);
    send_byte(8'h55);
    chk("t5_q_drained", exp_q.size(), 0);
    FLAG_FRAME = 1'b0;
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    chk("t5_rst_count",  int'(WORD_COUNT), 0);
    chk("t5_rst_active", int'(FRAME_ACTIVE), 0);
    chk("t5_rst_valid",  int'(WORD_VALID), 0);
    chk("t5_rst_flags",  int'({DATA_ACK, FRAME_DONE, FRAME_ERROR, OVERFLOW}), 0);
    tick(6);
    a0 = n_ack; d0 = n_done; done_wc = -1;
    frame_start();
    for (int i = 0; i < 64; i++) send_word(8'(8'h80 + i), 8'(8'hFF - i), 1'b1);
    tick(8);
    chk("t5_acks",    n_ack - a0, 64);
    chk("t5_done",    n_done - d0, 1);
    chk("t5_done_wc", done_wc, 64);
    chk("t5_err",     int'(FRAME_ERROR), 0);
    chk("t5_q_empty", exp_q.size(), 0);
    FLAG_FRAME = 1'b0;
    tick(6);

    // 6: DATA_CLK activity while idle
    do_reset();
    a0 = n_ack; p0 = n_pop;
    for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i));
    tick(4);
    chk("t6_acks",  n_ack - a0, 0);
    chk("t6_pops",  n_pop - p0, 0);
    chk("t6_valid", int'(WORD_VALID), 0);
    chk("t6_count", int'(WORD_COUNT), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
